// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, supported baud rates, bit timing
// and the bit-level FSM state type used by both the RX and TX controllers.
package uart_pkg;

  localparam logic [31:0] OffData   = 32'h0000_0000;
  localparam logic [31:0] OffValid  = 32'h0000_0004;
  localparam logic [31:0] OffBusy   = 32'h0000_0008;
  localparam logic [31:0] OffBaud   = 32'h0000_000C;
  localparam logic [31:0] OffParity = 32'h0000_0010;
  localparam logic [31:0] OffStop   = 32'h0000_0014;
  localparam logic [31:0] OffRst    = 32'h0000_0024;

  typedef enum logic [31:0] {
    Baud9600   = 32'd9600,
    Baud19200  = 32'd19200,
    Baud38400  = 32'd38400,
    Baud57600  = 32'd57600,
    Baud115200 = 32'd115200
  } baud_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Rounded clock cycles per bit period.
  function automatic logic [15:0] cycles_per_bit(int unsigned clk_hz, int unsigned baud);
    return 16'((clk_hz + baud / 2) / baud);
  endfunction

  function automatic logic is_supported_baud(logic [31:0] value);
    return (value == Baud9600)  || (value == Baud19200) || (value == Baud38400) ||
           (value == Baud57600) || (value == Baud115200);
  endfunction

endpackage

// File: rtl/uart_rx_sb_ctrl_rx.sv
// Bit-level UART receiver: 2-flop synchroniser, centre-sampling baud counter,
// frame FSM and LSB-first shift register. Emits a one-cycle pulse per good byte.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        rx_i,
  input  logic [15:0] cpb_i,
  input  logic        parity_en_i,
  input  logic [1:0]  stopbit_i,
  output logic        busy_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o
);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        drop_q, drop_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  stop_cnt_q, stop_cnt_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        rx_s;
  logic        expire;

  assign rx_s      = sync2_q;
  assign expire    = (cnt_q == 16'd0);
  assign busy_o    = (state_q != StIdle);
  assign rx_data_o = shift_q;

  // Synchroniser and previous-sample flop for start-edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else if (clr_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= rx_s;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      drop_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      drop_q     <= drop_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Next-state logic: each sample is taken when the counter reaches zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    drop_d     = drop_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    rx_valid_o = 1'b0;

    if (state_q != StIdle && !expire) begin
      cnt_d = cnt_q - 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (prev_q && !rx_s) begin
          state_d   = StStart;
          cnt_d     = (cpb_i >> 1) - 16'd1;
          bit_idx_d = 3'd0;
          par_d     = 1'b0;
          drop_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      StStart: begin
        if (expire) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = cpb_i - 16'd1;
          end
        end
      end
      StData: begin
        if (expire) begin
          shift_d = {rx_s, shift_q[7:1]};
          par_d   = par_q ^ rx_s;
          cnt_d   = cpb_i - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = parity_en_i ? StParity : StStop;
            stop_cnt_d = stopbit_i;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (expire) begin
          if (par_q ^ rx_s) begin
            drop_d = 1'b1;
          end
          cnt_d      = cpb_i - 16'd1;
          state_d    = StStop;
          stop_cnt_d = stopbit_i;
        end
      end
      StStop: begin
        // A low stop bit parks here until the line recovers.
        if (ferr_q) begin
          if (rx_s) begin
            state_d = StIdle;
          end
        end else if (expire) begin
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if (stop_cnt_q <= 2'd1) begin
            state_d    = StIdle;
            rx_valid_o = !drop_q;
          end else begin
            stop_cnt_d = stop_cnt_q - 2'd1;
            cnt_d      = cpb_i - 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr_i) begin
      state_d    = StIdle;
      cnt_d      = 16'd0;
      bit_idx_d  = 3'd0;
      shift_d    = 8'd0;
      par_d      = 1'b0;
      drop_d     = 1'b0;
      ferr_d     = 1'b0;
      stop_cnt_d = 2'd0;
      rx_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_sb_ctrl.sv
// System-bus UART receiver peripheral: register file, bus decode and
// byte-received interrupt around the bit-level receiver.
module uart_rx_sb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        rx_i
);

  localparam logic [15:0] Cpb9600   = cycles_per_bit(CLK_FREQ_HZ, 9600);
  localparam logic [15:0] Cpb19200  = cycles_per_bit(CLK_FREQ_HZ, 19200);
  localparam logic [15:0] Cpb38400  = cycles_per_bit(CLK_FREQ_HZ, 38400);
  localparam logic [15:0] Cpb57600  = cycles_per_bit(CLK_FREQ_HZ, 57600);
  localparam logic [15:0] Cpb115200 = cycles_per_bit(CLK_FREQ_HZ, 115200);

  logic [31:0] read_data_q, read_data_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;
  logic [31:0] baud_q, baud_d;
  logic        parity_en_q, parity_en_d;
  logic [1:0]  stopbit_q, stopbit_d;

  logic        rd_sel, wr_sel, soft_rst;
  logic [31:0] rdata;
  logic [15:0] cpb;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;

  assign rd_sel   = req_i && !write_enable_i;
  assign wr_sel   = req_i && write_enable_i;
  assign soft_rst = wr_sel && (addr_i == OffRst) && (write_data_i == 32'd1);

  assign read_data_o         = read_data_q;
  assign interrupt_request_o = irq_q;

  // Bit period for the currently selected rate.
  always_comb begin
    cpb = Cpb9600;
    case (baud_q)
      Baud19200:  cpb = Cpb19200;
      Baud38400:  cpb = Cpb38400;
      Baud57600:  cpb = Cpb57600;
      Baud115200: cpb = Cpb115200;
      default:    cpb = Cpb9600;
    endcase
  end

  uart_rx u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (soft_rst),
    .rx_i        (rx_i),
    .cpb_i       (cpb),
    .parity_en_i (parity_en_q),
    .stopbit_i   (stopbit_q),
    .busy_o      (busy),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid)
  );

  // Read mux; unmapped and write-only offsets read as zero.
  always_comb begin
    rdata = 32'd0;
    case (addr_i)
      OffData:   rdata = {24'd0, data_q};
      OffValid:  rdata = {31'd0, valid_q};
      OffBusy:   rdata = {31'd0, busy};
      OffBaud:   rdata = baud_q;
      OffParity: rdata = {31'd0, parity_en_q};
      OffStop:   rdata = {30'd0, stopbit_q};
      default:   rdata = 32'd0;
    endcase
  end

  // Register-file next state; later assignments take priority.
  always_comb begin
    read_data_d = read_data_q;
    data_d      = data_q;
    valid_d     = valid_q;
    irq_d       = irq_q;
    baud_d      = baud_q;
    parity_en_d = parity_en_q;
    stopbit_d   = stopbit_q;

    if (rd_sel) begin
      read_data_d = rdata;
      if (addr_i == OffData) begin
        valid_d = 1'b0;
        irq_d   = 1'b0;
      end
    end

    if (wr_sel) begin
      case (addr_i)
        OffBaud: begin
          if (!busy && is_supported_baud(write_data_i)) begin
            baud_d = write_data_i;
          end
        end
        OffParity: parity_en_d = write_data_i[0];
        OffStop: begin
          if (!busy && (write_data_i == 32'd1 || write_data_i == 32'd2)) begin
            stopbit_d = write_data_i[1:0];
          end
        end
        default: ;
      endcase
    end

    if (interrupt_return_i) begin
      irq_d = 1'b0;
    end

    // Completion beats both a data read and an interrupt return.
    if (rx_valid) begin
      data_d  = rx_data;
      valid_d = 1'b1;
      irq_d   = 1'b1;
    end

    if (soft_rst) begin
      read_data_d = 32'd0;
      data_d      = 8'd0;
      valid_d     = 1'b0;
      irq_d       = 1'b0;
      baud_d      = Baud9600;
      parity_en_d = 1'b1;
      stopbit_d   = 2'd1;
    end
  end

  // Register-file state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_data_q <= 32'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      irq_q       <= 1'b0;
      baud_q      <= Baud9600;
      parity_en_q <= 1'b1;
      stopbit_q   <= 2'd1;
    end else begin
      read_data_q <= read_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      irq_q       <= irq_d;
      baud_q      <= baud_d;
      parity_en_q <= parity_en_d;
      stopbit_q   <= stopbit_d;
    end
  end

endmodule
